// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory behind the cache miss/write-through engine.
// Serves single-word reads and byte-masked writes and pulses done (and err) on completion.
//
// Ports:
//   clk        in   1   clock, posedge
//   rst        in   1   synchronous active-high reset
//   rw_flag    in   2   0=none, 1=read, 2=write, 3=illegal (dropped)
//   addr       in   32  byte address, word index = addr[ADDR_WIDTH+1:2]
//   write_data in   32  write word, sampled at accept
//   write_mask in   4   byte enables, sampled at accept
//   read_data  out  32  last read word, held until the next read completes
//   busy       out  1   request in flight, new requests are dropped
//   done       out  1   one-cycle completion pulse
//   err        out  1   one-cycle pulse with done for an out-of-range address
module mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  rw_flag,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_mask,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    commit;

    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [3:0]              mask_q;
    logic                    oor_q;

    logic                    req_ok;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   in_idx;
    logic                    in_oor;

    logic                    cur_wr;
    logic [ADDR_WIDTH-1:0]   cur_idx;
    logic [31:0]             cur_data;
    logic [3:0]              cur_mask;
    logic                    cur_oor;

    logic [31:0]             ram [DEPTH];

    // Byte offset bits are intentionally ignored.
    logic                    unused_ok;
    assign unused_ok = ^addr[1:0];

    assign in_idx = addr[ADDR_WIDTH+1:2];
    assign in_oor = (addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign req_ok = (rw_flag == 2'd1) || (rw_flag == 2'd2);
    assign busy   = (state_q == WAIT);
    assign accept = req_ok && !busy;

    // A commit in IDLE only happens with LATENCY==1, where the request
    // completes on its own accept edge and the live inputs are used.
    always_comb begin
        if (busy) begin
            cur_wr   = wr_q;
            cur_idx  = idx_q;
            cur_data = wdata_q;
            cur_mask = mask_q;
            cur_oor  = oor_q;
        end else begin
            cur_wr   = (rw_flag == 2'd2);
            cur_idx  = in_idx;
            cur_data = write_data;
            cur_mask = write_mask;
            cur_oor  = in_oor;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'(LATENCY - 1)) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            read_data <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done    <= commit;
            err     <= commit && cur_oor;
            if (commit && !cur_wr) begin
                read_data <= cur_oor ? 32'd0 : ram[cur_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= (rw_flag == 2'd2);
            idx_q   <= in_idx;
            wdata_q <= write_data;
            mask_q  <= write_mask;
            oor_q   <= in_oor;
        end
    end

    // Reset aborts an in-flight write, so the RAM port is gated by rst.
    always_ff @(posedge clk) begin
        if (!rst && commit && cur_wr && !cur_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_mask[b]) begin
                    ram[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios plus randomized traffic against a
// due-time reference model of mem_responder.
module tb_mem_responder;

    localparam int AW  = 16;
    localparam int LAT = 4;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic [1:0]  rw_flag    = 2'd0;
    logic [31:0] addr       = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [3:0]  write_mask = 4'd0;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_responder #(
        .ADDR_WIDTH(AW),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rw_flag   (rw_flag),
        .addr      (addr),
        .write_data(write_data),
        .write_mask(write_mask),
        .read_data (read_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an accepted request completes at edge accept+LAT-1;
    // any request seen while one is pending is dropped.
    logic [31:0] mem_m [0:(1<<AW)-1];
    bit          pend   = 1'b0;
    int          due    = 0;
    int          cyc    = 0;
    bit          l_wr;
    logic [31:0] l_addr, l_data;
    logic [3:0]  l_mask;
    bit          m_done = 1'b0;
    bit          m_err  = 1'b0;
    logic [31:0] m_rd   = 32'd0;

    task automatic model_complete();
        int  idx;
        bit  oor;
        idx = int'(l_addr[AW+1:2]);
        oor = (l_addr / (32'd4 << AW)) != 0;
        m_done = 1'b1;
        m_err  = oor;
        if (!l_wr) begin
            m_rd = oor ? 32'd0 : mem_m[idx];
        end else if (!oor) begin
            for (int b = 0; b < 4; b++)
                if (l_mask[b]) mem_m[idx][8*b +: 8] = l_data[8*b +: 8];
        end
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            pend = 1'b0;
            m_rd = 32'd0;
        end else if (pend) begin
            if (cyc == due) begin
                model_complete();
                pend = 1'b0;
            end
        end else if (rw_flag == 2'd1 || rw_flag == 2'd2) begin
            l_wr   = (rw_flag == 2'd2);
            l_addr = addr;
            l_data = write_data;
            l_mask = write_mask;
            if (LAT == 1) begin
                model_complete();
            end else begin
                pend = 1'b1;
                due  = cyc + LAT - 1;
            end
        end
        cyc++;
        #1;
        chk("busy", {31'd0, busy}, {31'd0, pend});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("rdata", read_data, m_rd);
    end

    function automatic logic [31:0] pv(input int i);
        if (i == 5) return 32'hDEADBEEF;
        if (i == 8) return 32'hAAAAAAAA;
        return 32'hC0DE0000 + 32'(i);
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        rw_flag    = op;
        addr       = a;
        write_data = d;
        write_mask = m;
    endtask

    task automatic finish_txn(output int n);
        @(negedge clk);
        rw_flag = 2'd0;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic txn(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        int n;
        @(negedge clk);
        issue(op, a, d, m);
        finish_txn(n);
    endtask

    initial begin
        int n;
        int extra;
        int r;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            txn(2'd2, 32'(i * 4), pv(i), 4'hF);

        // Read of a preloaded word with full latency measurement.
        @(negedge clk);
        issue(2'd1, 32'h14, 32'd0, 4'd0);
        finish_txn(n);
        chk("t1_lat", 32'(n), 32'(LAT));
        chk("t1_data", read_data, 32'hDEADBEEF);

        // Partial-mask write then read back.
        txn(2'd2, 32'h20, 32'h11223344, 4'b0101);
        chk("t2_wr_keep", read_data, 32'hDEADBEEF);
        txn(2'd1, 32'h20, 32'd0, 4'd0);
        chk("t2_data", read_data, 32'hAA22AA44);

        // Back-to-back: second request presented in the done cycle.
        txn(2'd1, 32'h0, 32'd0, 4'd0);
        chk("t3_first", read_data, pv(0));
        issue(2'd1, 32'h4, 32'd0, 4'd0);
        finish_txn(n);
        chk("t3_b2b_lat", 32'(n), 32'(LAT));
        chk("t3_data", read_data, pv(1));

        // Request while busy is dropped.
        @(negedge clk);
        issue(2'd1, 32'h14, 32'd0, 4'd0);
        @(negedge clk);
        rw_flag = 2'd0;
        @(negedge clk);
        issue(2'd2, 32'h14, 32'h0, 4'hF);
        @(negedge clk);
        rw_flag = 2'd0;
        n = 3;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t4_done", {31'd0, done}, 32'd1);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("t4_extra", 32'(extra), 32'd0);
        txn(2'd1, 32'h14, 32'd0, 4'd0);
        chk("t4_keep", read_data, 32'hDEADBEEF);

        // Out-of-range write and read.
        txn(2'd2, 32'h0004_0000, 32'h12345678, 4'hF);
        chk("t5_wr_err", {31'd0, err}, 32'd1);
        txn(2'd1, 32'h0004_0000, 32'd0, 4'd0);
        chk("t5_rd_err", {31'd0, err}, 32'd1);
        chk("t5_rd_zero", read_data, 32'd0);
        txn(2'd1, 32'h0, 32'd0, 4'd0);
        chk("t5_ram_keep", read_data, pv(0));

        // Reset aborts an in-flight write.
        @(negedge clk);
        issue(2'd2, 32'h24, 32'h55555555, 4'hF);
        @(negedge clk);
        rw_flag = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        repeat (4) @(negedge clk);
        chk("t6_idle", {31'd0, done}, 32'd0);
        txn(2'd1, 32'h24, 32'd0, 4'd0);
        chk("t6_old", read_data, pv(9));

        // Zero mask write completes without changing RAM.
        txn(2'd2, 32'hC, 32'hFFFFFFFF, 4'd0);
        chk("mask0_done", {31'd0, done}, 32'd1);
        txn(2'd1, 32'hC, 32'd0, 4'd0);
        chk("mask0_keep", read_data, pv(3));

        // Randomized traffic including drops, illegal ops and resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 119) == 0);
            r = $urandom_range(0, 9);
            rw_flag = (r < 3) ? 2'd0 : 2'($urandom_range(1, 3));
            addr = {($urandom_range(0, 7) == 0) ? 14'($urandom_range(1, 16383))
                                                : 14'd0,
                    12'd0, 4'($urandom), 2'($urandom)};
            write_data = $urandom;
            write_mask = 4'($urandom);
        end
        @(negedge clk);
        rst     = 1'b0;
        rw_flag = 2'd0;
        repeat (2 * LAT + 2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
